// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write arbiter: FSM states, buffered MDU
// result entry and the hard-wired zero register.
package rf_arb_pkg;

   localparam int RF_ADDR_W = 5;
   localparam int RF_DATA_W = 32;

   localparam logic [RF_ADDR_W-1:0] ZERO_REG = '0;

   typedef enum logic {
      ARB  = 1'b0,
      HOLD = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic [RF_ADDR_W-1:0] addr;
      logic [RF_DATA_W-1:0] data;
   } rf_entry_t;

endpackage

// File: rtl/rf_result_fifo.sv
// Small synchronous FIFO for MDU results. Storage is not reset; only the
// pointers and occupancy count are, which is enough to discard its contents.
module rf_result_fifo #(
   parameter int W     = 37,
   parameter int DEPTH = 2,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push_i,
   input  logic [W-1:0]  push_data_i,
   input  logic          pop_i,
   output logic [W-1:0]  head_o,
   output logic [CW-1:0] count_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(push_i);
      rd_ptr_d = rd_ptr_q + AW'(pop_i);
      count_d  = count_q + CW'(push_i) - CW'(pop_i);
   end

   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between WB and buffered MDU results,
// with a starvation guard and a pending-write scoreboard for the hazard unit.
module regfile_write_arbiter
   import rf_arb_pkg::*;
#(
   parameter int DATA_W     = RF_DATA_W,
   parameter int ADDR_W     = RF_ADDR_W,
   parameter int BUF_DEPTH  = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              md_valid,
   input  logic [ADDR_W-1:0] md_addr,
   input  logic [DATA_W-1:0] md_data,
   output logic              md_ready,
   input  logic              md_issue_valid,
   input  logic [ADDR_W-1:0] md_issue_addr,
   input  logic [ADDR_W-1:0] dec_rs,
   input  logic [ADDR_W-1:0] dec_rt,
   input  logic [ADDR_W-1:0] dec_rd,
   output logic              sb_stall,
   output logic              wb_hold,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              proto_err,
   output logic              dbg_state
);

   localparam int NREG = 1 << ADDR_W;
   localparam int CW   = $clog2(BUF_DEPTH) + 1;
   localparam int SW   = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(BUF_DEPTH);
   localparam logic [SW-1:0] CNT_LAST = SW'(STARVE_MAX - 1);

   rf_entry_t     push_entry, head_entry;
   logic [CW-1:0] fifo_count;
   logic          fifo_empty, push, pop, wb_req, wb_win, proto_set;

   arb_state_t    state_q, state_d;
   logic [SW-1:0] starve_q, starve_d;
   logic [NREG-1:0] pending_q, pending_d;
   logic          rf_we_q, rf_we_d;
   logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
   logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
   logic          proto_q;

   // MDU handshake: a result transfers on a rising edge where md_valid and
   // md_ready are both high; md_ready depends only on the pre-edge count.
   assign md_ready   = reset & (fifo_count < FULL_CNT);
   assign push       = md_valid & md_ready & (md_addr != ZERO_REG);
   assign fifo_empty = (fifo_count == '0);
   assign wb_req     = wb_valid & (wb_addr != ZERO_REG);
   assign push_entry = '{addr: md_addr, data: md_data};

   rf_result_fifo #(
      .W     ($bits(rf_entry_t)),
      .DEPTH (BUF_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .head_o      (head_entry),
      .count_o     (fifo_count)
   );

   always_comb begin
      pop       = 1'b0;
      wb_win    = 1'b0;
      proto_set = 1'b0;
      if ((state_q == HOLD) && !fifo_empty) begin
         pop       = 1'b1;
         proto_set = wb_req;
      end else if (wb_req) begin
         wb_win = 1'b1;
      end else if (!fifo_empty) begin
         pop = 1'b1;
      end
   end

   always_comb begin
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (pop) begin
         rf_we_d    = 1'b1;
         rf_waddr_d = head_entry.addr;
         rf_wdata_d = head_entry.data;
      end else if (wb_win) begin
         rf_we_d    = 1'b1;
         rf_waddr_d = wb_addr;
         rf_wdata_d = wb_data;
      end
   end

   // Starvation guard: count consecutive WB wins over a waiting MDU result.
   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      unique case (state_q)
         ARB: begin
            if (pop || fifo_empty) begin
               starve_d = '0;
            end else if (wb_win) begin
               if (starve_q == CNT_LAST) begin
                  state_d  = HOLD;
                  starve_d = '0;
               end else begin
                  starve_d = starve_q + SW'(1);
               end
            end
         end
         HOLD: begin
            state_d  = ARB;
            starve_d = '0;
         end
         default: begin
            state_d  = ARB;
            starve_d = '0;
         end
      endcase
   end

   // A new issue to the register being drained must stay pending, so set wins.
   always_comb begin
      pending_d = pending_q;
      if (pop) begin
         pending_d[head_entry.addr] = 1'b0;
      end
      if (md_issue_valid && (md_issue_addr != ZERO_REG)) begin
         pending_d[md_issue_addr] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ARB;
         starve_q   <= '0;
         pending_q  <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         proto_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         starve_q   <= starve_d;
         pending_q  <= pending_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         proto_q    <= proto_q | proto_set;
      end
   end

   assign sb_stall  = pending_q[dec_rs] | pending_q[dec_rt] | pending_q[dec_rd];
   assign wb_hold   = (state_q == HOLD);
   assign dbg_state = state_q;
   assign rf_we     = rf_we_q;
   assign rf_waddr  = rf_waddr_q;
   assign rf_wdata  = rf_wdata_q;
   assign proto_err = proto_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a queue-based reference model is
// checked every cycle, and literal expectations pin the key scenarios.
module tb_regfile_write_arbiter;

   localparam int STARVE_MAX = 4;
   localparam int BUF_DEPTH  = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_addr = '0;
   logic [31:0] wb_data = '0;
   logic        md_valid = 1'b0;
   logic [4:0]  md_addr = '0;
   logic [31:0] md_data = '0;
   logic        md_ready;
   logic        md_issue_valid = 1'b0;
   logic [4:0]  md_issue_addr = '0;
   logic [4:0]  dec_rs = '0, dec_rt = '0, dec_rd = '0;
   logic        sb_stall, wb_hold, rf_we, proto_err, dbg_state;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   int total = 0;
   int bad = 0;

   regfile_write_arbiter dut (
      .clk(clk), .reset(reset),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data), .md_ready(md_ready),
      .md_issue_valid(md_issue_valid), .md_issue_addr(md_issue_addr),
      .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_rd(dec_rd),
      .sb_stall(sb_stall), .wb_hold(wb_hold),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .proto_err(proto_err), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [36:0] mq[$];
   bit          m_hold = 0;
   int          m_starve = 0;
   bit [31:0]   m_pend = '0;
   bit          m_proto = 0;
   bit          m_we = 0;
   logic [4:0]  m_addr = '0;
   logic [31:0] m_data = '0;

   task automatic m_reset();
      mq.delete();
      m_hold = 0; m_starve = 0; m_pend = '0; m_proto = 0;
      m_we = 0; m_addr = '0; m_data = '0;
   endtask

   task automatic m_step();
      logic [36:0] e;
      bit nonempty, ready, popped, wb_won, wb_req;
      e = '0;
      nonempty = (mq.size() != 0);
      ready    = (mq.size() < BUF_DEPTH);
      wb_req   = wb_valid && (wb_addr != 0);
      popped = 0; wb_won = 0;
      if (m_hold && nonempty) begin
         e = mq.pop_front(); popped = 1;
         if (wb_req) m_proto = 1;
      end else if (wb_req) begin
         wb_won = 1;
      end else if (nonempty) begin
         e = mq.pop_front(); popped = 1;
      end
      if (popped) begin
         m_we = 1; m_addr = e[36:32]; m_data = e[31:0];
      end else if (wb_won) begin
         m_we = 1; m_addr = wb_addr; m_data = wb_data;
      end else begin
         m_we = 0;
      end
      if (md_valid && ready && md_addr != 0) mq.push_back({md_addr, md_data});
      if (m_hold) begin
         m_hold = 0; m_starve = 0;
      end else if (nonempty && wb_won) begin
         if (m_starve == STARVE_MAX - 1) begin
            m_hold = 1; m_starve = 0;
         end else begin
            m_starve++;
         end
      end else begin
         m_starve = 0;
      end
      if (popped) m_pend[e[36:32]] = 1'b0;
      if (md_issue_valid && md_issue_addr != 0) m_pend[md_issue_addr] = 1'b1;
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) m_reset();
      else m_step();
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      check("m_rf_we", 32'(rf_we), 32'(m_we));
      if (m_we || !reset) begin
         check("m_rf_waddr", 32'(rf_waddr), 32'(m_addr));
         check("m_rf_wdata", rf_wdata, m_data);
      end
      check("m_wb_hold", 32'(wb_hold), 32'(m_hold));
      check("m_proto_err", 32'(proto_err), 32'(m_proto));
      check("m_md_ready", 32'(md_ready), 32'(reset && (mq.size() < BUF_DEPTH)));
      check("m_sb_stall", 32'(sb_stall), 32'(m_pend[dec_rs] | m_pend[dec_rt] | m_pend[dec_rd]));
   endtask

   always @(posedge clk) begin
      #1;
      compare_all();
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive_wb(input logic v, input logic [4:0] a, input logic [31:0] d);
      wb_valid = v; wb_addr = a; wb_data = d;
   endtask

   task automatic drive_md(input logic v, input logic [4:0] a, input logic [31:0] d);
      md_valid = v; md_addr = a; md_data = d;
   endtask

   task automatic drive_issue(input logic v, input logic [4:0] a);
      md_issue_valid = v; md_issue_addr = a;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rf_we"}, 32'(rf_we), 0);
      check({tag, "_rf_waddr"}, 32'(rf_waddr), 0);
      check({tag, "_rf_wdata"}, rf_wdata, 0);
      check({tag, "_wb_hold"}, 32'(wb_hold), 0);
      check({tag, "_proto_err"}, 32'(proto_err), 0);
      check({tag, "_sb_stall"}, 32'(sb_stall), 0);
      check({tag, "_md_ready"}, 32'(md_ready), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // reset state
      tick(); tick();
      check_all_zero("rst");
      reset = 1'b1;

      // single MDU result reaches the port one edge after acceptance
      drive_md(1, 5'd8, 32'h1234);
      #1 check("t1_md_ready", 32'(md_ready), 1);
      tick();
      drive_md(0, 0, 0);
      check("t1_no_early_we", 32'(rf_we), 0);
      tick();
      check("t1_rf_we", 32'(rf_we), 1);
      check("t1_rf_waddr", 32'(rf_waddr), 8);
      check("t1_rf_wdata", rf_wdata, 32'h1234);
      tick();

      // WB and MDU collide: WB first, MDU the cycle after
      drive_wb(1, 5'd3, 32'hA);
      drive_md(1, 5'd4, 32'hB);
      tick();
      drive_wb(0, 0, 0); drive_md(0, 0, 0);
      check("t2_wb_addr", 32'(rf_waddr), 3);
      check("t2_wb_data", rf_wdata, 32'hA);
      tick();
      check("t2_md_we", 32'(rf_we), 1);
      check("t2_md_addr", 32'(rf_waddr), 4);
      check("t2_md_data", rf_wdata, 32'hB);
      tick();

      // register 0 is never written
      drive_wb(1, 5'd0, 32'h5);
      tick();
      drive_wb(0, 0, 0);
      check("t3_wb_r0", 32'(rf_we), 0);
      drive_md(1, 5'd0, 32'h7);
      #1 check("t3_md_r0_ready", 32'(md_ready), 1);
      tick();
      drive_md(0, 0, 0);
      check("t3_md_r0_a", 32'(rf_we), 0);
      tick();
      check("t3_md_r0_b", 32'(rf_we), 0);

      // scoreboard set/clear and set-wins collision
      drive_issue(1, 5'd9);
      dec_rs = 5'd9;
      #1 check("t4_not_yet", 32'(sb_stall), 0);
      tick();
      drive_issue(0, 0);
      check("t4_set_rs", 32'(sb_stall), 1);
      dec_rs = 0; dec_rt = 5'd9;
      #1 check("t4_set_rt", 32'(sb_stall), 1);
      dec_rt = 0; dec_rd = 5'd9;
      #1 check("t4_set_rd", 32'(sb_stall), 1);
      dec_rd = 0; dec_rs = 5'd9;
      tick();
      check("t4_held", 32'(sb_stall), 1);
      drive_md(1, 5'd9, 32'h99);
      tick();
      drive_md(0, 0, 0);
      check("t4_buffered", 32'(sb_stall), 1);
      tick();
      check("t4_pop_addr", 32'(rf_waddr), 9);
      check("t4_cleared", 32'(sb_stall), 0);
      drive_issue(1, 5'd9);
      tick();
      drive_issue(0, 0);
      drive_md(1, 5'd9, 32'h77);
      tick();
      drive_md(0, 0, 0);
      drive_issue(1, 5'd9);
      tick();
      drive_issue(0, 0);
      check("t4_coll_data", rf_wdata, 32'h77);
      check("t4_set_wins", 32'(sb_stall), 1);
      drive_md(1, 5'd9, 32'h55);
      tick();
      drive_md(0, 0, 0);
      tick();
      check("t4_final_clear", 32'(sb_stall), 0);
      dec_rs = 0;

      // starvation: one buffered result against continuous WB
      drive_wb(1, 5'd5, 32'h100);
      drive_md(1, 5'd12, 32'hC);
      tick();
      drive_md(0, 0, 0);
      check("t5_first_wb", rf_wdata, 32'h100);
      for (int i = 1; i <= 3; i++) begin
         drive_wb(1, 5'd5, 32'h100 + i);
         tick();
         check("t5_no_hold", 32'(wb_hold), 0);
         check("t5_wb_data", rf_wdata, 32'h100 + i);
      end
      drive_wb(1, 5'd5, 32'h104);
      tick();
      check("t5_hold", 32'(wb_hold), 1);
      check("t5_proto_before", 32'(proto_err), 0);
      drive_wb(1, 5'd5, 32'h105);
      tick();
      check("t5_head_addr", 32'(rf_waddr), 12);
      check("t5_head_data", rf_wdata, 32'hC);
      check("t5_proto", 32'(proto_err), 1);
      check("t5_hold_off", 32'(wb_hold), 0);
      drive_wb(1, 5'd5, 32'h106);
      tick();
      check("t5_wb_resume", rf_wdata, 32'h106);

      // fill the buffer, then reset in the middle of the stream
      drive_wb(1, 5'd6, 32'h200);
      drive_md(1, 5'd20, 32'h20);
      tick();
      drive_wb(1, 5'd6, 32'h201);
      drive_md(1, 5'd21, 32'h21);
      tick();
      drive_md(0, 0, 0);
      check("t6_full", 32'(md_ready), 0);
      check("t6_proto_sticky", 32'(proto_err), 1);
      #1 reset = 1'b0;
      drive_wb(0, 0, 0);
      #1 check_all_zero("t6_rst");
      tick(); tick();
      reset = 1'b1;
      #1 check("t6_ready_after", 32'(md_ready), 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t6_no_stale", 32'(rf_we), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
